// File: rtl/rate_counter.sv
// -----------------------------------------------------------------------------
// rate_counter
//
// 16-bit up/down counter that advances at a selectable rate. A 26-bit
// down-counter divides clk into count-enable ticks. A run/stop FSM toggles
// on each rising edge of the start_stop request. A synchronous load writes
// the counter at any time.
//
// State table
//   STOPPED | divider and Q hold, no ticks issued
//   RUNNING | divider counts down, a tick is issued on each terminal count
//
// Parameters
//   CLK_HZ      clk frequency in Hz; sets the 1/2/4 Hz divider terminal counts
//
// Ports
//   clk         single clock, all state updates on its rising edge
//   clear       asynchronous active-low reset
//   start_stop  run/stop request level; each rising edge toggles the FSM
//   rate_sel    00 = every clk, 01 = 1 Hz, 10 = 2 Hz, 11 = 4 Hz
//   down        0 counts up, 1 counts down
//   load        synchronous load strobe, writes load_value into Q
//   load_value  value written into Q on load
//   Q           count value (nibble 0 drives HEX0 ... nibble 3 drives HEX3)
//   tick        single-cycle count-enable pulse
//   wrap        single-cycle pulse on the tick that wraps Q
//   running     high while the FSM is in RUNNING
// -----------------------------------------------------------------------------
module rate_counter #(
    parameter int CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start_stop,
    input  logic [1:0]  rate_sel,
    input  logic        down,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] Q,
    output logic        tick,
    output logic        wrap,
    output logic        running
);

    // Divider terminal counts; a tick fires every TERM+1 clocks.
    localparam logic [25:0] TERM_1HZ = 26'(CLK_HZ - 1);
    localparam logic [25:0] TERM_2HZ = 26'(CLK_HZ / 2 - 1);
    localparam logic [25:0] TERM_4HZ = 26'(CLK_HZ / 4 - 1);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        running_q, running_d;
    logic        ss_q;
    logic [1:0]  rs_q;
    logic [25:0] div_cnt_q, div_cnt_d;
    logic [15:0] cnt_q, cnt_d;

    logic        ss_rise;
    logic        rate_change;
    logic        div_zero;
    logic [25:0] term_sel;

    function automatic logic [25:0] term_of(input logic [1:0] sel);
        logic [25:0] t;
        case (sel)
            2'b00:   t = 26'd0;
            2'b01:   t = TERM_1HZ;
            2'b10:   t = TERM_2HZ;
            default: t = TERM_4HZ;
        endcase
        return t;
    endfunction

    assign ss_rise     = start_stop & ~ss_q;
    assign rate_change = (rate_sel != rs_q);
    assign div_zero    = (div_cnt_q == 26'd0);
    assign term_sel    = term_of(rate_sel);

    // Tick is judged in the pre-edge state, so a stop that lands on the
    // terminal count still delivers that final count.
    assign tick = running_q & div_zero & ~load & ~rate_change;
    assign wrap = tick & ((~down & (cnt_q == 16'hFFFF)) |
                          ( down & (cnt_q == 16'h0000)));

    assign Q       = cnt_q;
    assign running = running_q;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;

        case (state_q)
            STOPPED: begin
                if (ss_rise) begin
                    state_d   = RUNNING;
                    div_cnt_d = term_sel;
                end
            end
            RUNNING: begin
                if (ss_rise) begin
                    state_d = STOPPED;
                end
                // Load or a rate change restarts the divider phase so the
                // next tick is a full period of the (possibly new) rate away.
                if (load || rate_change || div_zero) begin
                    div_cnt_d = term_sel;
                end else begin
                    div_cnt_d = div_cnt_q - 26'd1;
                end
            end
            default: begin
                state_d   = STOPPED;
                div_cnt_d = 26'd0;
            end
        endcase

        running_d = (state_d == RUNNING);
    end

    // Load wins over a tick in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (tick) begin
            if (down) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q   <= STOPPED;
            running_q <= 1'b0;
            ss_q      <= 1'b0;
            rs_q      <= 2'b00;
            div_cnt_q <= 26'd0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            ss_q      <= start_stop;
            rs_q      <= rate_sel;
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rate_counter.sv
// -----------------------------------------------------------------------------
// tb_rate_counter
//
// Directed bench for rate_counter at CLK_HZ = 8 (terminal counts 0/7/3/1).
// Each step pushes the expected {Q, tick, wrap, running} to a scoreboard,
// then pops and compares it against the DUT sampled 3 time units after the
// rising edge, with inputs changed 2 units after the edge.
// -----------------------------------------------------------------------------
module tb_rate_counter;

    logic        clk;
    logic        clear;
    logic        start_stop;
    logic [1:0]  rate_sel;
    logic        down;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] Q;
    logic        tick;
    logic        wrap;
    logic        running;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic        t;
        logic        w;
        logic        r;
    } exp_t;

    exp_t sb[$];

    rate_counter #(.CLK_HZ(8)) dut (
        .clk        (clk),
        .clear      (clear),
        .start_stop (start_stop),
        .rate_sel   (rate_sel),
        .down       (down),
        .load       (load),
        .load_value (load_value),
        .Q          (Q),
        .tick       (tick),
        .wrap       (wrap),
        .running    (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic clk1();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] q,
                              input logic t, input logic w, input logic r);
        exp_t e;
        e.tag = tag;
        e.q   = q;
        e.t   = t;
        e.w   = w;
        e.r   = r;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        assert ({Q, tick, wrap, running} === {e.q, e.t, e.w, e.r})
        else begin
            failures++;
            $error("FAIL %s: got Q=%h tick=%b wrap=%b running=%b, expected Q=%h tick=%b wrap=%b running=%b",
                   e.tag, Q, tick, wrap, running, e.q, e.t, e.w, e.r);
        end
    endtask

    initial begin
        clear      = 1'b1;
        start_stop = 1'b0;
        rate_sel   = 2'b00;
        down       = 1'b0;
        load       = 1'b0;
        load_value = 16'h0000;
        #3;
        clear = 1'b0;
        expect_out("reset", 16'h0000, 0, 0, 0);

        // ---- 1 Hz: first tick 8 cycles after start, then every 8 ----
        clk1();
        clear    = 1'b1;
        rate_sel = 2'b01;
        expect_out("post_release", 16'h0000, 0, 0, 0);
        clk1();
        start_stop = 1'b1;
        expect_out("start_req", 16'h0000, 0, 0, 0);
        clk1();
        start_stop = 1'b0;
        expect_out("started", 16'h0000, 0, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            clk1();
            expect_out("r1_wait0", 16'h0000, 0, 0, 1);
        end
        clk1();
        expect_out("r1_tick0", 16'h0000, 1, 0, 1);
        clk1();
        expect_out("r1_q1", 16'h0001, 0, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            clk1();
            expect_out("r1_wait1", 16'h0001, 0, 0, 1);
        end
        clk1();
        expect_out("r1_tick1", 16'h0001, 1, 0, 1);
        clk1();
        expect_out("r1_q2", 16'h0002, 0, 0, 1);

        // ---- every clk: 5 ticks then stop, Q holds ----
        rate_sel   = 2'b00;
        load       = 1'b1;
        load_value = 16'h0000;
        expect_out("r0_load_ratechg", 16'h0002, 0, 0, 1);
        clk1();
        load = 1'b0;
        expect_out("r0_c0", 16'h0000, 1, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            clk1();
            expect_out("r0_cnt", 16'(i), 1, 0, 1);
        end
        start_stop = 1'b1;
        expect_out("r0_stop_req", 16'h0004, 1, 0, 1);
        clk1();
        start_stop = 1'b0;
        expect_out("r0_stopped", 16'h0005, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            clk1();
            expect_out("r0_hold", 16'h0005, 0, 0, 0);
        end

        // ---- load FFFE with simultaneous start, count up across wrap ----
        load       = 1'b1;
        load_value = 16'hFFFE;
        start_stop = 1'b1;
        expect_out("wrap_up_setup", 16'h0005, 0, 0, 0);
        clk1();
        load       = 1'b0;
        start_stop = 1'b0;
        expect_out("wrap_up_fffe", 16'hFFFE, 1, 0, 1);
        clk1();
        expect_out("wrap_up_ffff", 16'hFFFF, 1, 1, 1);
        clk1();
        expect_out("wrap_up_0000", 16'h0000, 1, 0, 1);
        clk1();
        expect_out("wrap_up_0001", 16'h0001, 1, 0, 1);

        // ---- load 0001, 4 Hz, count down across wrap ----
        load       = 1'b1;
        load_value = 16'h0001;
        down       = 1'b1;
        rate_sel   = 2'b11;
        expect_out("dn_load_in_tick", 16'h0001, 0, 0, 1);
        clk1();
        load = 1'b0;
        expect_out("dn_loaded", 16'h0001, 0, 0, 1);
        clk1();
        expect_out("dn_tick1", 16'h0001, 1, 0, 1);
        clk1();
        expect_out("dn_q0", 16'h0000, 0, 0, 1);
        clk1();
        expect_out("dn_tick0_wrap", 16'h0000, 1, 1, 1);
        clk1();
        expect_out("dn_qffff", 16'hFFFF, 0, 0, 1);
        clk1();
        expect_out("dn_tick_ffff", 16'hFFFF, 1, 0, 1);

        // ---- rate change at terminal count suppresses the tick ----
        down     = 1'b0;
        rate_sel = 2'b01;
        expect_out("rc_at_zero", 16'hFFFF, 0, 0, 1);
        clk1();
        expect_out("rc_reload", 16'hFFFF, 0, 0, 1);
        clk1();
        expect_out("rc_div6", 16'hFFFF, 0, 0, 1);
        clk1();
        expect_out("rc_div5", 16'hFFFF, 0, 0, 1);
        // 1 Hz -> 2 Hz mid-count: next tick exactly 4 cycles later
        rate_sel = 2'b10;
        expect_out("rc_change", 16'hFFFF, 0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            clk1();
            expect_out("rc_wait", 16'hFFFF, 0, 0, 1);
        end
        clk1();
        expect_out("rc_tick_wrap", 16'hFFFF, 1, 1, 1);
        clk1();
        expect_out("rc_q0", 16'h0000, 0, 0, 1);

        // ---- load in a tick cycle: load wins, no increment ----
        clk1();
        expect_out("ld_div2", 16'h0000, 0, 0, 1);
        clk1();
        expect_out("ld_div1", 16'h0000, 0, 0, 1);
        clk1();
        load       = 1'b1;
        load_value = 16'h1234;
        expect_out("ld_in_tick", 16'h0000, 0, 0, 1);
        clk1();
        load = 1'b0;
        expect_out("ld_1234", 16'h1234, 0, 0, 1);

        // ---- async clear mid-count, then restart from a fresh phase ----
        clk1();
        clear = 1'b0;
        expect_out("clr_async", 16'h0000, 0, 0, 0);
        clk1();
        expect_out("clr_held", 16'h0000, 0, 0, 0);
        clear = 1'b1;
        clk1();
        expect_out("clr_released", 16'h0000, 0, 0, 0);
        clk1();
        expect_out("clr_no_tick", 16'h0000, 0, 0, 0);
        start_stop = 1'b1;
        clk1();
        start_stop = 1'b0;
        expect_out("rst_started", 16'h0000, 0, 0, 1);
        for (int i = 1; i <= 2; i++) begin
            clk1();
            expect_out("rst_wait", 16'h0000, 0, 0, 1);
        end
        clk1();
        expect_out("rst_tick", 16'h0000, 1, 0, 1);
        clk1();
        expect_out("rst_q1", 16'h0001, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rate_counter.md
RATE_COUNTER -- requirements
Module: rate_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning clk frequency in Hz; benches override it with a small value.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start_stop, input, 1 bit: run/stop request level, from a push-button or switch.
REQ-005 SHALL have port rate_sel, input, 2 bits: count rate, 00=every clk, 01=1 Hz, 10=2 Hz, 11=4 Hz.
REQ-006 SHALL have port down, input, 1 bit: 0 counts up, 1 counts down.
REQ-007 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 SHALL have port load_value, input, 16 bits: value written to Q on load.
REQ-009 SHALL have port Q, output, 16 bits: count value; feeds four hex-digit decoders, nibble 0 to HEX0 through nibble 3 to HEX3.
REQ-010 SHALL have port tick, output, 1 bit: single-cycle count-enable pulse.
REQ-011 SHALL have port wrap, output, 1 bit: single-cycle pulse marking a Q wrap-around.
REQ-012 SHALL have port running, output, 1 bit: high while the FSM is in RUNNING.

Function
REQ-013 SHALL use a two-state FSM, STOPPED and RUNNING.
REQ-014 SHALL register start_stop once (ss_q); a rising edge is defined as start_stop=1 and ss_q=0.
REQ-015 SHALL toggle the state on each rising edge; levels and falling edges SHALL have no effect.
REQ-016 SHALL define the divider terminal count TERM as: 00 -> 0, 01 -> CLK_HZ-1, 10 -> CLK_HZ/2-1, 11 -> CLK_HZ/4-1 (integer division).
REQ-017 SHALL hold a 26-bit down-counter div_cnt that is wide enough for TERM at CLK_HZ=50000000.
REQ-018 SHALL load div_cnt with TERM(rate_sel) on the clk edge where the state changes STOPPED -> RUNNING.
REQ-019 In RUNNING, div_cnt SHALL reload TERM(rate_sel) when div_cnt=0 and SHALL otherwise decrement by 1.
REQ-020 In STOPPED, div_cnt SHALL hold its value, tick SHALL be 0, and Q SHALL hold.
REQ-021 SHALL drive tick combinationally as running AND div_cnt=0 AND NOT load AND NOT rate_change.
REQ-022 SHALL space ticks exactly TERM+1 cycles apart; the first tick SHALL occur TERM+1 cycles after running rises.
REQ-023 SHALL register rate_sel (rs_q); rate_change is rate_sel != rs_q.
REQ-024 On rate_change while RUNNING, div_cnt SHALL reload TERM(new rate_sel) and no tick SHALL be issued that cycle.
REQ-025 On the clk edge ending a tick cycle, Q SHALL become Q+1 when down=0 and Q-1 when down=1, modulo 2^16.
REQ-026 SHALL drive wrap combinationally as tick AND ((down=0 AND Q=16'hFFFF) OR (down=1 AND Q=16'h0000)).
REQ-027 On load=1, Q SHALL be written with load_value on that edge, regardless of state.
REQ-028 On load=1 while RUNNING, div_cnt SHALL reload TERM(rate_sel) on that edge.
REQ-029 load SHALL have priority over a tick in the same cycle, and SHALL NOT change the FSM state.
REQ-030 A start_stop rising edge coinciding with load SHALL be honoured: both the toggle and the load take effect on the same edge.
REQ-031 A stop (RUNNING -> STOPPED) coinciding with div_cnt=0 SHALL still produce that cycle's tick and Q update, because tick is evaluated in the pre-edge state.
REQ-032 A change of down SHALL take effect at the next tick, with no glitch on Q.

Reset
REQ-033 On clear=0, the block SHALL immediately and asynchronously set Q=0, state=STOPPED, div_cnt=0, ss_q=0, rs_q=0.
REQ-034 While clear=0, the outputs SHALL be Q=0, tick=0, wrap=0, running=0.
REQ-035 SHALL release reset synchronously to the next clk edge with clear=1; no tick is issued until a start_stop rising edge.
REQ-036 Assertion of clear mid-count SHALL abandon the divider phase; the post-reset first tick obeys REQ-022.

Verification (CLK_HZ=8, so TERM = 0/7/3/1)
REQ-037 SHALL cover: reset, rate_sel=01, one start_stop pulse -> running=1, first tick 8 cycles later, Q=1; ticks every 8 cycles thereafter.
REQ-038 SHALL cover: rate_sel=00, running, 5 cycles -> a tick every cycle, Q=5; second start_stop pulse -> running=0, Q holds 5.
REQ-039 SHALL cover: load 16'hFFFE, down=0, rate_sel=00, run 3 cycles -> Q sequence FFFF, 0000, 0001; wrap=1 only in the FFFF tick cycle.
REQ-040 SHALL cover: load 16'h0001, down=1, rate_sel=11 -> Q=0000 after 2 cycles, then FFFF with wrap=1, ticks every 2 cycles.
REQ-041 SHALL cover: rate_sel 01 -> 10 mid-count -> no tick in the change cycle, next tick exactly 4 cycles later.
REQ-042 SHALL cover: clear pulsed low between clk edges while running at Q=16'h1234 -> Q=0, running=0 immediately; load asserted in a tick cycle -> Q=load_value, no increment.
